regfile_write_port: RTL

- Write side of the register file: the counterpart to the 32:1 read-select path.
- Accepts write-back requests (register select + data) over a valid/ready handshake and buffers them in a 2-entry in-order queue.
- Retires one queued write per enabled cycle into a 32 x n register bank, using one-hot decode of the 5-bit select.
- Exposes the bank as a flat bus for the read muxes, plus a pending-write query for hazard detection.

---
 rtl/regfile_write_port.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register file.
// Write-back requests enter a 2-deep in-order queue over a valid/ready handshake.
// The queue retires one entry per enabled cycle into the bank through a one-hot decode.
// The bank is exposed flat for the read muxes.
// A pending-write query supports hazard detection.
module regfile_write_port #(
    parameter int n        = 8,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_select,
    input  logic [n-1:0]    in_data,
    input  logic            commit_en,
    input  logic            flush,
    input  logic [4:0]      query_select,
    output logic            query_hit,
    output logic [1:0]      count,
    output logic [32*n-1:0] regs_flat
);

    logic [4:0]   r_q_sel  [2];
    logic [n-1:0] r_q_data [2];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_count;
    logic [n-1:0] r_regs   [32];

    logic         w_accept;
    logic         w_commit;
    logic [4:0]   w_head_sel;
    logic [n-1:0] w_head_data;
    logic [31:0]  w_dec;
    logic [1:0]   w_entry_valid;

    // Readiness comes from occupancy alone, never from a same-cycle commit.
    assign in_ready    = (r_count != 2'd2);
    assign count       = r_count;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_commit    = (r_count != 2'd0) && commit_en && !flush;
    assign w_head_sel  = r_q_sel[r_head];
    assign w_head_data = r_q_data[r_head];

    // One-hot write enable for the head entry; register 31 is never enabled when hard-wired zero.
    always_comb begin
        w_dec             = 32'd0;
        w_dec[w_head_sel] = w_commit;
        if (ZERO_REG) begin
            w_dec[31] = 1'b0;
        end
    end

    // Queue storage, pointers and occupancy; flush empties the queue and blocks accept and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_sel[0]  <= 5'd0;
            r_q_sel[1]  <= 5'd0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_count     <= 2'd0;
        end else if (flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_accept) begin
                r_q_sel[r_tail]  <= in_select;
                r_q_data[r_tail] <= in_data;
                r_tail           <= ~r_tail;
            end
            if (w_commit) begin
                r_head <= ~r_head;
            end
            case ({w_accept, w_commit})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Register bank; the head entry lands in whichever register its decode selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_dec[i]) begin
                    r_regs[i] <= w_head_data;
                end
            end
        end
    end

    // Occupied slots: with one entry only the head slot holds live data.
    always_comb begin
        w_entry_valid[0] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b0));
        w_entry_valid[1] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b1));
    end

    // Pending-write lookup; the zero register never has a meaningful pending write.
    always_comb begin
        query_hit = (w_entry_valid[0] && (r_q_sel[0] == query_select))
                 || (w_entry_valid[1] && (r_q_sel[1] == query_select));
        if (ZERO_REG && (query_select == 5'd31)) begin
            query_hit = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_flat
            if (ZERO_REG && (gi == 31)) begin : g_zero
                assign regs_flat[gi*n +: n] = '0;
            end else begin : g_reg
                assign regs_flat[gi*n +: n] = r_regs[gi];
            end
        end
    endgenerate

endmodule
